// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial: digit-serial packed-BCD adder/subtractor with start/done handshake.
// Processes one BCD digit per clock, least significant first. Subtraction is done as
// A + tens-complement(B); a missing end carry means A < B, and a second serial pass
// takes the tens-complement of the working result to produce a sign-magnitude answer.
// Optional build macro: BCD_ADDSUB_SAT_EN -- when defined, an add that carries out of
// the top digit saturates the result to all nines instead of wrapping modulo 10^DIGITS.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  neg,
  output logic                  overflow,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_COMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // One decimal digit step: {carry_out, digit} of x + y + cin with BCD correction.
  function automatic logic [4:0] dec_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (s > 5'd9) begin
      dec_digit = {1'b1, 4'(s - 5'd10)};
    end else begin
      dec_digit = {1'b0, s[3:0]};
    end
  endfunction

  // Registered state
  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               op_sub_q, op_sub_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [3:0]         work_q [DIGITS];
  logic [3:0]         work_d [DIGITS];
  logic               inv_w_q, inv_w_d;
  logic               neg_w_q, neg_w_d;
  logic               ovf_w_q, ovf_w_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W-1:0]       result_q, result_d;
  logic               neg_q, neg_d;
  logic               overflow_q, overflow_d;
  logic               invalid_q, invalid_d;

  // Per-digit views of the latched operands and the working result
  logic [3:0]         a_dig [DIGITS];
  logic [3:0]         b_dig [DIGITS];
  logic [W-1:0]       work_flat;
  logic [DIGITS-1:0]  digit_bad;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign a_dig[gi]              = a_q[4*gi +: 4];
      assign b_dig[gi]              = b_q[4*gi +: 4];
      assign work_flat[4*gi +: 4]   = work_q[gi];
      // Validity is checked on the live inputs, since it decides the first transition.
      assign digit_bad[gi]          = (a[4*gi +: 4] > 4'd9) || (b[4*gi +: 4] > 4'd9);
    end
  endgenerate

  logic       any_bad;
  logic       is_last;
  logic [3:0] b_eff;
  logic [3:0] comp_in;
  logic [4:0] calc_step;
  logic [4:0] comp_step;

  assign any_bad = |digit_bad;
  assign is_last = (idx_q == LAST_IDX);

  // Next-state and datapath logic for the whole sequencer
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_sub_d   = op_sub_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    work_d     = work_q;
    inv_w_d    = inv_w_q;
    neg_w_d    = neg_w_q;
    ovf_w_d    = ovf_w_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    neg_d      = neg_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;

    // Nines-complement of B when subtracting; the initial carry of 1 completes the tens-complement.
    b_eff     = op_sub_q ? (4'd9 - b_dig[idx_q]) : b_dig[idx_q];
    calc_step = dec_digit(a_dig[idx_q], b_eff, carry_q);
    comp_in   = 4'd9 - work_q[idx_q];
    comp_step = dec_digit(comp_in, 4'd0, carry_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_sub_d = op_sub;
          idx_d    = '0;
          carry_d  = op_sub;
          for (int i = 0; i < DIGITS; i++) begin
            work_d[i] = 4'd0;
          end
          inv_w_d  = any_bad;
          neg_w_d  = 1'b0;
          ovf_w_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = any_bad ? S_DONE : S_CALC;
        end
      end

      S_CALC: begin
        work_d[idx_q] = calc_step[3:0];
        carry_d       = calc_step[4];
        if (is_last) begin
          idx_d = '0;
          if (!op_sub_q) begin
            ovf_w_d = calc_step[4];
            state_d = S_DONE;
`ifdef BCD_ADDSUB_SAT_EN
            if (calc_step[4]) begin
              for (int i = 0; i < DIGITS; i++) begin
                work_d[i] = 4'd9;
              end
            end
`endif
          end else if (calc_step[4]) begin
            // End carry present: A >= B and the working value is already the magnitude.
            state_d = S_DONE;
          end else begin
            // No end carry: A < B, so recomplement the working value for the magnitude.
            neg_w_d = 1'b1;
            carry_d = 1'b1;
            state_d = S_COMP;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_COMP: begin
        work_d[idx_q] = comp_step[3:0];
        carry_d       = comp_step[4];
        if (is_last) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        result_d   = inv_w_q ? '0 : work_flat;
        neg_d      = !inv_w_q && neg_w_q;
        overflow_d = !inv_w_q && ovf_w_q;
        invalid_d  = inv_w_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any operation in flight without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_sub_q   <= 1'b0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        work_q[i] <= 4'd0;
      end
      inv_w_q    <= 1'b0;
      neg_w_q    <= 1'b0;
      ovf_w_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_sub_q   <= op_sub_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      work_q     <= work_d;
      inv_w_q    <= inv_w_d;
      neg_w_q    <= neg_w_d;
      ovf_w_q    <= ovf_w_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      neg_q      <= neg_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign neg      = neg_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial (DIGITS=4). Expected results come from an
// integer decimal model; BCD_ADDSUB_SAT_EN selects the saturating add expectation.
module tb_bcd_addsub_serial;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int POW = 10 ** D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, neg, overflow, invalid;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .neg      (neg),
    .overflow (overflow),
    .invalid  (invalid)
  );

  typedef struct {
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         sub;
    logic [W-1:0] res;
    logic         neg;
    logic         ovf;
    logic         inv;
    int           lat;
    int           e0;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  logic [W-1:0] held_res = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v;
    int           t;
    t = n;
    for (int i = 0; i < D; i++) begin
      v[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  // Advance one cycle to the falling edge, then act as the output monitor.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) return;
    if (sb.size() == 0) begin
      check_eq("no_done", 32'(done), 32'd0);
    end else if (done) begin
      e = sb.pop_front();
      $display("op a=%h b=%h sub=%0d -> result=%h neg=%0d ovf=%0d inv=%0d lat=%0d",
               e.av, e.bv, e.sub, result, neg, overflow, invalid, cyc - e.e0);
      check_eq("result",   32'(result),   32'(e.res));
      check_eq("neg",      32'(neg),      32'(e.neg));
      check_eq("overflow", 32'(overflow), 32'(e.ovf));
      check_eq("invalid",  32'(invalid),  32'(e.inv));
      check_eq("latency",  32'(cyc - e.e0), 32'(e.lat));
      check_eq("busy_in_done", 32'(busy), 32'd0);
      check_eq("busy_cycles",  32'(busy_cnt), 32'(e.lat));
      held_res = e.res;
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check_eq("hold", 32'(result), 32'(held_res));
      end
    end
  endtask

  // Build the expectation, push it, and pulse start (optionally a second, ignored pulse).
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                        input bit dup);
    exp_t e;
    bit   bad;
    int   ai, bi, s;
    bad = 0;
    for (int i = 0; i < D; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1;
    end
    ai = bcd2int(av);
    bi = bcd2int(bv);
    e.av = av; e.bv = bv; e.sub = sub;
    e.neg = 1'b0; e.ovf = 1'b0; e.inv = 1'b0;
    if (bad) begin
      e.res = '0; e.inv = 1'b1; e.lat = 1;
    end else if (!sub) begin
      s = ai + bi;
      e.lat = D + 1;
      if (s >= POW) begin
        e.ovf = 1'b1;
`ifdef BCD_ADDSUB_SAT_EN
        e.res = int2bcd(POW - 1);
`else
        e.res = int2bcd(s - POW);
`endif
      end else begin
        e.res = int2bcd(s);
      end
    end else if (ai >= bi) begin
      e.res = int2bcd(ai - bi); e.lat = D + 1;
    end else begin
      e.res = int2bcd(bi - ai); e.neg = 1'b1; e.lat = 2 * D + 1;
    end
    e.e0 = cyc + 1;
    sb.push_back(e);
    a = av; b = bv; op_sub = sub; start = 1'b1;
    tick();
    start = 1'b0;
    if (dup) begin
      tick();
      start = 1'b1;
      op_sub = ~sub;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                       input bit dup);
    launch(av, bv, sub, dup);
    drain();
  endtask

  initial begin
    int e0;
    logic [W-1:0] ra, rb;

    // Reset state
    tick();
    tick();
    check_eq("reset_state", 32'({busy, done, neg, overflow, invalid, result}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic add, with an extra start pulse while busy that must be ignored
    do_op(16'h1234, 16'h5678, 1'b0, 1'b1);
    // Wrap / saturate on carry out
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    // Positive and negative subtract
    do_op(16'h0500, 16'h0123, 1'b1, 1'b0);
    do_op(16'h0123, 16'h0500, 1'b1, 1'b1);
    // Invalid digits in A, then in B
    do_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
    do_op(16'h0001, 16'h00F0, 1'b1, 1'b0);

    // Reset in the middle of a negative subtract
    launch(16'h0123, 16'h0500, 1'b1, 1'b0);
    e0 = cyc;
    while (cyc < e0 + 5) tick();
    rst_n = 1'b0;
    #1;
    check_eq("reset_abort", 32'({busy, done, neg, overflow, invalid, result}), 32'd0);
    sb.delete();
    held_res = '0;
    busy_cnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Zero results are never negative
    do_op(16'h0042, 16'h0042, 1'b1, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b1, 1'b0);

    // Back-to-back random traffic: each start lands in the done cycle of the previous op
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
Parametrised, digit-serial BCD adder/subtractor for the calculator datapath. It replaces the fixed two-digit combinational unit. It handles DIGITS packed BCD digits with a start/done handshake and correct decimal carry. Subtraction returns a sign-magnitude result. It sits between the operand entry registers and the display formatter.

Parameters:
DIGITS, 4, number of packed BCD digits per operand/result (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = A+B, 1 = A-B; latched with start
a  input  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0]
b  input  4*DIGITS  operand B, packed BCD
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  4*DIGITS  BCD magnitude of the result
neg  output  1  result is negative (subtract only)
overflow  output  1  add carry out of the most significant digit
invalid  output  1  an operand digit was greater than 9

Behaviour:
- Reset: clk and rst_n form the single domain; reset is asynchronous, active-low. All outputs reset to 0 (busy, done, result, neg, overflow, invalid), state = IDLE, internal registers = 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, COMP, DONE.
- Edge numbering: E0 is the edge where start=1 in IDLE. At E0 the block latches a, b and op_sub, and checks every digit of a and b.
  - If any digit > 9, go to DONE.
  - Otherwise go to CALC with digit index 0, carry = op_sub, and the working result register cleared.
- start while not in IDLE is ignored; no queueing.
- CALC, one digit per edge starting at digit 0:
  - bd = op_sub ? 9 - b_i : b_i
  - s = a_i + bd + carry, a 5-bit sum
  - If s > 9: digit = s - 10, carry = 1. Else digit = s, carry = 0.
  - On the last digit (E0+DIGITS), the final carry is cout.
  - Add: go to DONE, overflow = cout, neg = 0.
  - Sub with cout = 1: go to DONE, neg = 0, result is positive.
  - Sub with cout = 0: go to COMP, neg = 1, carry = 1, index = 0.
- COMP, one digit per edge: digit = (9 - r_i) + carry, with the same decimal correction. This takes the tens-complement of the working result, giving the magnitude.
- DONE, entered on the next edge:
  - Load result, neg, overflow and invalid from working values. If invalid, result = 0 and neg = overflow = 0.
  - done = 1 for exactly one cycle, then go to IDLE.
- Latency from E0 to the edge that raises done:
  - add or positive subtract: DIGITS+1
  - negative subtract: 2*DIGITS+1
  - invalid: 1
- busy is high from E0 until the edge that raises done; it is low in the done cycle. A new start may be accepted in the cycle after done.
- result and flags hold their previous values until the next DONE load. They are not cleared at start.
- 0-0 gives result 0 with neg = 0; a zero subtract result is never negative.
- Width: the working carry is 1 bit and digit arithmetic is 5 bits. overflow is meaningful only for add and is 0 for subtract.

Optional Feature:
BCD_ADDSUB_SAT_EN
- Defined: on add with cout = 1, result loads all nines (9 in every digit) and overflow = 1.
- Undefined: result wraps modulo 10^DIGITS (for example 9999+0001 gives 0000) and overflow = 1.
- Subtract is unaffected in both builds.

Test Plan:
1. DIGITS=4: a=0x1234, b=0x5678, op_sub=0, start -> done at E0+5, result=0x6912, neg=0, overflow=0, invalid=0; busy high for 5 cycles.
2. a=0x9999, b=0x0001 add -> result=0x0000, overflow=1 (with BCD_ADDSUB_SAT_EN: result=0x9999, overflow=1), done at E0+5.
3. a=0x0500, b=0x0123, op_sub=1 -> result=0x0377, neg=0, done at E0+5. Swap operands -> result=0x0377, neg=1, done at E0+9.
4. a=0x12A4, b=0x0001 -> done at E0+1, invalid=1, result=0x0000; a second start pulse during busy in any other test -> ignored, single done.
5. Start a negative subtract, drop rst_n at E0+6 -> all outputs 0 immediately, no done. After release, 0x0042-0x0042 -> result=0x0000, neg=0.
6. Back-to-back: start asserted the cycle after done -> accepted. Previous result stays stable until the new done.
